// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared widths and FSM state type for the memory bridge.
package mem_bridge_pkg;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_bridge_ram.sv
// mem_bridge_ram: single-port synchronous RAM, per-byte write enables, one-cycle read latency.
module mem_bridge_ram
   import mem_bridge_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++)
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end else begin
            rdata_q <= mem[addr];
         end
      end
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: CPU request bridge to a synchronous RAM with programmable wait states.
// Define MEM_BRIDGE_ADDR_CHECK_EN to fault accesses whose upper address bits fall outside the RAM.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err
);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    flt_q, flt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [BE_W-1:0]         be_q, be_d;
   logic                    flt_in;
   logic [DATA_W-1:0]       ram_rdata;
   logic                    unused_addr;
`ifdef MEM_BRIDGE_ADDR_CHECK_EN
   assign flt_in      = |addr[31:DEPTH_LOG2+2];
   assign unused_addr = ^addr[1:0];
`else
   assign flt_in      = 1'b0;
   assign unused_addr = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      flt_d   = flt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         IDLE: if (req) begin
            we_d    = we;
            flt_d   = flt_in;
            idx_d   = addr[DEPTH_LOG2+1:2];
            wdata_d = wdata;
            be_d    = be;
            cnt_d   = WAIT_INIT;
            state_d = (WAIT_INIT == 4'd0) ? ACCESS : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
         end
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         flt_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         flt_q   <= flt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end
   // A faulted access never touches the RAM; it still walks the FSM so latency is unchanged.
   mem_bridge_ram #(.AW(DEPTH_LOG2)) u_ram (
      .clk   (clk),
      .en    (state_q == ACCESS && !flt_q),
      .we    (we_q),
      .be    (be_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );
   assign busy  = state_q != IDLE;
   assign ack   = state_q == RESP;
   assign err   = ack && flt_q;
   assign rdata = (ack && !we_q && !flt_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: two bridges (WAIT_CYCLES=2 and 0) on shared stimulus, checked against a transaction-level model.
module tb_mem_bridge;
   localparam int DL = 10;
`ifdef MEM_BRIDGE_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        ack_o [2], busy_o [2], err_o [2];
   logic [31:0] rdata_o [2];
   int          checks = 0, errors = 0;
   bit          mon_en = 1'b0;
   always #5 clk = ~clk;
   mem_bridge #(.DEPTH_LOG2(DL), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack_o[0]), .rdata(rdata_o[0]), .busy(busy_o[0]), .err(err_o[0]));
   mem_bridge #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack_o[1]), .rdata(rdata_o[1]), .busy(busy_o[1]), .err(err_o[1]));
   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", nm, d, act, exp);
      end
   endtask
   // Model: each access occupies WAIT_CYCLES+2 busy cycles; ack in the last one; writes land at end of ACCESS.
   int          rem [2];
   logic        m_we [2], m_flt [2];
   bit          m_rk [2];
   int          m_idx [2];
   logic [31:0] m_wd [2], m_resp [2];
   logic [3:0]  m_be [2];
   logic [31:0] mm [2][1024];
   bit          kn [2][1024];
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mon_en) begin
            chk("busy", d, 32'(busy_o[d]), 32'(rem[d] != 0));
            chk("ack", d, 32'(ack_o[d]), 32'(rem[d] == 1));
            chk("err", d, 32'(err_o[d]), 32'(rem[d] == 1 && m_flt[d]));
            if (rem[d] != 1 || m_rk[d])
               chk("rdata", d, rdata_o[d], rem[d] == 1 ? m_resp[d] : 32'h0);
         end
         if (rem[d] == 2 && m_we[d] && !m_flt[d]) begin
            for (int i = 0; i < 4; i++)
               if (m_be[d][i]) mm[d][m_idx[d]][8*i +: 8] = m_wd[d][8*i +: 8];
            kn[d][m_idx[d]] = kn[d][m_idx[d]] || (m_be[d] == 4'hF);
         end
         if (rst) rem[d] = 0;
         else if (rem[d] != 0) rem[d]--;
         else if (req) begin
            m_we[d]   = we;
            m_idx[d]  = int'((addr >> 2) % (1 << DL));
            m_flt[d]  = CHK && ((addr >> (DL + 2)) != 0);
            m_wd[d]   = wdata;
            m_be[d]   = be;
            rem[d]    = (d == 0 ? 2 : 0) + 2;
            m_rk[d]   = m_we[d] || m_flt[d] || kn[d][m_idx[d]];
            m_resp[d] = (m_we[d] || m_flt[d]) ? 32'h0 : mm[d][m_idx[d]];
         end
      end
   end
   task automatic wait_idle();
      for (int n = 0; n < 50 && (rem[0] != 0 || rem[1] != 0); n++) begin
         @(posedge clk); #1;
      end
      chk("idle", 0, 32'(rem[0] + rem[1]), 32'h0);
   endtask
   // Latencies count from the cycle in which req is presented (cycle 0).
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] b,
                         output logic [31:0] rd0, output logic [31:0] rd1, output logic e0,
                         output int l0, output int l1);
      wait_idle();
      req = 1'b1; we = w; addr = a; wdata = dat; be = b;
      l0 = -1; l1 = -1; rd0 = '0; rd1 = '0; e0 = 1'b0;
      @(posedge clk); #1 req = 1'b0;
      for (int n = 1; n <= 20 && (l0 < 0 || l1 < 0); n++) begin
         @(negedge clk);
         if (ack_o[0] && l0 < 0) begin l0 = n; rd0 = rdata_o[0]; e0 = err_o[0]; end
         if (ack_o[1] && l1 < 0) begin l1 = n; rd1 = rdata_o[1]; end
      end
      @(posedge clk); #1;
   endtask
   initial begin
      logic [31:0] r0, r1;
      logic        e;
      int          l0, l1, na, last;
      bit          pa;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ack", 0, 32'(ack_o[0]), 32'h0);
      chk("rst_busy", 0, 32'(busy_o[0]), 32'h0);
      chk("rst_rdata", 0, rdata_o[0], 32'h0);
      chk("rst_err", 0, 32'(err_o[0]), 32'h0);
      @(posedge clk); #1 rst = 1'b0; mon_en = 1'b1;
      access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r0, r1, e, l0, l1);
      chk("wr_lat", 0, l0, 4);
      access(1'b0, 32'h10, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("rd_lat", 0, l0, 4);
      chk("rd_data", 0, r0, 32'hDEADBEEF);
      chk("rd_err", 0, 32'(e), 32'h0);
      access(1'b1, 32'h13, 32'hFFFFFFFF, 4'h0, r0, r1, e, l0, l1);
      access(1'b0, 32'h11, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("be0_keep", 0, r0, 32'hDEADBEEF);
      access(1'b1, 32'h20, 32'h11223344, 4'hF, r0, r1, e, l0, l1);
      access(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, r0, r1, e, l0, l1);
      access(1'b0, 32'h20, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("merge", 0, r0, 32'h11BB33DD);
      wait_idle();
      req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
      na = 0; last = -1; pa = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (pa) begin
            chk("busy_after_ack", 0, 32'(busy_o[0]), 32'h0);
            if (na == 3) break;
         end
         pa = ack_o[0];
         if (pa) begin
            na++;
            if (last >= 0) chk("ack_spacing", 0, c - last, 5);
            last = c;
         end
         @(posedge clk); #1;
         if (na == 3) req = 1'b0;
      end
      req = 1'b0;
      chk("held_acks", 0, na, 3);
      @(posedge clk); #1;
      access(1'b1, 32'h30, 32'h12345678, 4'hF, r0, r1, e, l0, l1);
      wait_idle();
      req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h0BADF00D; be = 4'hF;
      @(posedge clk); #1 req = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      na = 0;
      repeat (8) begin
         @(negedge clk);
         if (ack_o[0]) na++;
      end
      @(posedge clk); #1;
      chk("abort_no_ack", 0, na, 0);
      access(1'b0, 32'h30, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("abort_keep", 0, r0, 32'h12345678);
      access(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r0, r1, e, l0, l1);
      access(1'b0, 32'h0001_0000, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("hi_err", 0, 32'(e), 32'(CHK));
      chk("hi_rdata", 0, r0, CHK ? 32'h0 : 32'hCAFEF00D);
      chk("hi_lat", 0, l0, 4);
      access(1'b1, 32'h4, 32'h55AA1234, 4'hF, r0, r1, e, l0, l1);
      chk("w0_wr_lat", 1, l1, 2);
      access(1'b0, 32'h4, 32'h0, 4'h0, r0, r1, e, l0, l1);
      chk("w0_rd_lat", 1, l1, 2);
      chk("w0_rd_data", 1, r1, 32'h55AA1234);
      wait_idle();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words.
- WAIT_CYCLES, 2, extra wait states per access; 0..15.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset, synchronous, active-high.
- req, in, 1, request strobe from CPU.
- we, in, 1, 1=write, 0=read.
- addr, in, 32, byte address.
- wdata, in, 32, write data.
- be, in, 4, byte enables for writes; be[i] covers wdata[8i+7:8i].
- ack, out, 1, one-cycle completion pulse.
- rdata, out, 32, read data, valid when ack=1.
- busy, out, 1, access in progress.
- err, out, 1, address fault, valid when ack=1.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high on rst.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, ACCESS, RESP.
REQ-005 In IDLE with req=1, the block SHALL latch we/addr/wdata/be and go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-006 busy SHALL be 1 in WAIT, ACCESS and RESP, and 0 in IDLE.
REQ-007 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to ACCESS.
REQ-008 ACCESS SHALL last one cycle.
- Write: commits only the enabled bytes.
- Read: issues the synchronous RAM read.
- Then go to RESP.
REQ-009 RESP SHALL last one cycle with ack=1, then go to IDLE.
- Read: rdata holds the RAM word.
- Write: rdata=0.
REQ-010 ack SHALL rise exactly WAIT_CYCLES+2 cycles after the accept edge.
REQ-011 req SHALL be ignored outside IDLE; no queuing.
REQ-012 A req=1 in the cycle after ack SHALL be accepted, giving a peak throughput of one access per WAIT_CYCLES+3 cycles.
REQ-013 Word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] SHALL be ignored.
REQ-014 A write with be=0 SHALL complete normally with no RAM change.
REQ-015 A read SHALL return all 4 bytes regardless of be.
REQ-016 Outside RESP, ack, err and rdata SHALL be 0.

Reset
REQ-017 On rst=1 at a clock edge:
- State goes to IDLE; counter clears.
- ack=0, busy=0, rdata=0, err=0.
REQ-018 Reset mid-operation SHALL abort the access:
- A write not yet in ACCESS SHALL NOT commit.
- No ack for the aborted access.
REQ-019 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro MEM_BRIDGE_ADDR_CHECK_EN SHALL control address checking.
- Defined: any nonzero addr[31:DEPTH_LOG2+2] faults.
- On a fault: no RAM access; RESP gives ack=1, err=1, rdata=0; latency unchanged.
REQ-021 Without MEM_BRIDGE_ADDR_CHECK_EN:
- Upper address bits SHALL be ignored, so addresses alias modulo RAM size.
- err SHALL be constant 0.

Structure
REQ-022 Package mem_bridge_pkg SHALL hold the FSM state typedef (2-bit), the data width constant 32 and the byte-enable width constant 4.
REQ-023 Sub-module mem_bridge_ram SHALL implement a single-port synchronous RAM:
- 2**DEPTH_LOG2 x 32 bits, per-byte write enables.
- One-cycle read latency.

Verification
REQ-024 Reset, then write addr=0x10, wdata=0xDEADBEEF, be=0xF; then read addr=0x10 -> read ack 4 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-025 Write addr=0x20, wdata=0x11223344, be=0xF; then write addr=0x20, wdata=0xAABBCCDD, be=0x5; then read addr=0x20 -> rdata=0x11BB33DD.
REQ-026 Hold req=1 continuously for 3 reads, WAIT_CYCLES=2 -> exactly 3 ack pulses, 5 cycles apart, each with busy=0 in the cycle after ack.
REQ-027 Start write addr=0x30, wdata=0x0BADF00D; assert rst in the first WAIT cycle; then read addr=0x30 -> no ack for the aborted write, rdata equals the prior contents of word 0x30.
REQ-028 With MEM_BRIDGE_ADDR_CHECK_EN defined, read addr=0x0001_0000 -> ack with err=1, rdata=0. Without it, the same read returns word 0.
REQ-029 With WAIT_CYCLES=0, write then read addr=0x4 -> ack 2 cycles after accept, data correct.
